serial_word_loader: RTL and testbench
=====================================

Name: serial_word_loader

Overview:
Parametrised serial programming engine for PLL/synthesizer control registers. It shifts a configurable number of words out over a 3-wire interface (sdata, sclk, le) and pulses le after each word. Timing is programmable in clk cycles, and a start/busy/done handshake is provided. It replaces the fixed-pattern init generator and sits between the control FSM and the synthesizer pins.

Parameters:
WORD_W, 21, bits per word (>=2)
N_WORDS, 3, words per sequence (>=1)
DIV, 4, clk cycles per sclk half-period (>=1)
LE_HOLD, 2, clk cycles le stays high per word (>=1)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request, sampled on rising edge, honoured only when busy=0
words_flat  in  N_WORDS*WORD_W  word i = bits [i*WORD_W +: WORD_W], word 0 sent first
busy  out  1  high while a sequence is in progress
done  out  1  one-cycle pulse after the final word
sdata  out  1  serial data
sclk  out  1  serial clock, idles low
le  out  1  latch enable, idles low

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset: state IDLE. busy, done, sdata, sclk and le are all 0, effective immediately. Reset mid-sequence aborts with no le pulse. The next start begins again from word 0.
- States: IDLE, SHIFT_LO, SHIFT_HI, LE_SETUP, LATCH, GAP.
- IDLE: start=1 snapshots words_flat into an internal register. It also sets word_idx=0 and selects the first bit. The next state is SHIFT_LO, and busy=1 from the next cycle. words_flat changes after acceptance have no effect.
- SHIFT_LO: lasts DIV cycles with sclk=0. sdata holds the current bit for the whole state.
- SHIFT_HI: lasts DIV cycles with sclk=1. The slave samples sdata on the rising edge of sclk.
  - If bits remain: advance to the next bit (sdata changes together with sclk falling) and go to SHIFT_LO.
  - Otherwise: go to LE_SETUP.
- LE_SETUP: lasts DIV cycles with sclk=0 and sdata=0.
- LATCH: lasts LE_HOLD cycles with le=1.
- GAP: lasts DIV cycles with le=0.
  - If word_idx < N_WORDS-1: increment word_idx, load the first bit of the next word, and go to SHIFT_LO.
  - Otherwise: go to IDLE with busy=0 and done=1 for exactly one cycle.
- Cycle counts:
  - Per word: T_W = 2*DIV*WORD_W + 2*DIV + LE_HOLD.
  - busy is high for exactly N_WORDS*T_W cycles.
  - done fires in the first cycle after busy falls.
- start while busy=1 is ignored (no queuing). start in the done cycle (busy=0) is accepted, so back-to-back sequences have a period of N_WORDS*T_W+1.
- sclk, sdata and le are registered and glitch-free. le and sclk are never high simultaneously.
- Counter widths:
  - phase counter: $clog2(max(DIV, LE_HOLD)+1)
  - bit counter: $clog2(WORD_W)
  - word counter: $clog2(N_WORDS)+1
  - All counters use no wrap beyond their terminal values.

Decomposition:
- Shared package holds the state enum (IDLE..GAP) and the T_W cycle-count function, both used by RTL and bench.
- One natural sub-module, swl_phase_timer: loadable down-counter with a terminal-count flag. The FSM reloads it with DIV-1 or LE_HOLD-1 on each state entry.
- Parameter legality is checked by elaboration-time assertions.

Test Plan:
1. Assert rst_n=0 with start=1 -> busy, done, sdata, sclk, le all 0. Release -> they stay 0 until start.
2. WORD_W=8, N_WORDS=2, DIV=2, LE_HOLD=3, MSB_FIRST=1, words 0xA5 then 0x3C; pulse start ->
   - sdata on sclk rises reads 10100101, then a 3-cycle le pulse, then 00111100, then a 3-cycle le pulse;
   - busy high for 78 cycles, done high for 1 cycle.
3. Same config with MSB_FIRST=0, word0=0x01, word1=0x80 -> bit streams 10000000 and 00000001.
4. Pulse start again and toggle words_flat during busy -> no restart; transmitted data equals the snapshot; exactly one done.
5. Drop rst_n during bit 4 of word 1 -> outputs go to 0 without waiting for clk; no le. The next start transmits word 0 in full.
6. WORD_W=2, N_WORDS=1, DIV=1, LE_HOLD=1, start held high -> each sequence is 7 busy cycles plus 1 done cycle, repeating with period 8.

Source files
------------

// File: rtl/serial_word_loader_pkg.sv
// Shared types and timing helpers for the serial word loader.
package serial_word_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LE_SETUP,
    LATCH,
    GAP
  } swl_state_e;

  // Busy cycles spent on one word: WORD_W sclk periods, LE_SETUP, LATCH and GAP.
  function automatic int unsigned word_cycles(int unsigned word_w,
                                               int unsigned div,
                                               int unsigned le_hold);
    return 2 * div * word_w + 2 * div + le_hold;
  endfunction

endpackage

// File: rtl/serial_word_loader_phase_timer.sv
// Loadable down-counter that stops at zero and flags its terminal count.
module swl_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load on request, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/serial_word_loader.sv
// Serial programming engine: shifts N_WORDS words out on sdata/sclk and
// pulses le after each word, with a start/busy/done handshake.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WORD_W    = 21,
  parameter int N_WORDS   = 3,
  parameter int DIV       = 4,
  parameter int LE_HOLD   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_WORDS*WORD_W-1:0] words_flat,
  output logic                      busy,
  output logic                      done,
  output logic                      sdata,
  output logic                      sclk,
  output logic                      le
);

  localparam int PH_MAX = (DIV > LE_HOLD) ? DIV : LE_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = $clog2(WORD_W);
  localparam int WC_W   = $clog2(N_WORDS) + 1;
  localparam int TOT_W  = N_WORDS * WORD_W;

  localparam logic [PH_W-1:0] DIV_LD    = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] LE_LD     = PH_W'(LE_HOLD - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(N_WORDS - 1);

  if (WORD_W < 2) begin : g_bad_word_w
    $error("serial_word_loader: WORD_W must be >= 2");
  end
  if (N_WORDS < 1) begin : g_bad_n_words
    $error("serial_word_loader: N_WORDS must be >= 1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("serial_word_loader: DIV must be >= 1");
  end
  if (LE_HOLD < 1) begin : g_bad_le_hold
    $error("serial_word_loader: LE_HOLD must be >= 1");
  end

  swl_state_e       state_q, state_d;
  logic [TOT_W-1:0] words_q, words_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic [WC_W-1:0]  word_q, word_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sdata_q, sdata_d;
  logic             sclk_q, sclk_d;
  logic             le_q, le_d;
  logic             ph_load;
  logic [PH_W-1:0]  ph_val;
  logic             ph_tc;

  swl_phase_timer #(
    .W(PH_W)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .tc_o       (ph_tc)
  );

  // Next-state logic plus snapshot / bit / word sequencing.
  // Remaining words live in words_q and are shifted down one word per GAP,
  // so the next word is always found in the low WORD_W bits.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    word_d  = word_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT_LO;
          words_d = words_flat;
          sh_d    = words_flat[WORD_W-1:0];
          bit_d   = '0;
          word_d  = '0;
        end
      end
      SHIFT_LO: begin
        if (ph_tc) begin
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (ph_tc) begin
          if (bit_q == BIT_LAST) begin
            state_d = LE_SETUP;
          end else begin
            state_d = SHIFT_LO;
            bit_d   = bit_q + BC_W'(1);
            if (MSB_FIRST) begin
              sh_d = {sh_q[WORD_W-2:0], 1'b0};
            end else begin
              sh_d = {1'b0, sh_q[WORD_W-1:1]};
            end
          end
        end
      end
      LE_SETUP: begin
        if (ph_tc) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (ph_tc) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (ph_tc) begin
          if (word_q == WORD_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT_LO;
            word_d  = word_q + WC_W'(1);
            words_d = words_q >> WORD_W;
            sh_d    = words_d[WORD_W-1:0];
            bit_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values and phase-timer reload derived from the state being entered,
  // so every output is registered and changes in step with the state.
  always_comb begin
    ph_load = (state_d != state_q);
    ph_val  = (state_d == LATCH) ? LE_LD : DIV_LD;
    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d == SHIFT_HI);
    le_d    = (state_d == LATCH);
    sdata_d = 1'b0;
    if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) begin
      sdata_d = MSB_FIRST ? sh_d[WORD_W-1] : sh_d[0];
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      words_q <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      le_q    <= le_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sdata = sdata_q;
  assign sclk  = sclk_q;
  assign le    = le_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: three configurations, a pin-level monitor and
// a reference built from the bit order / cycle-count rules.
module tb_serial_word_loader;
  import serial_word_loader_pkg::*;

  localparam int PW [3] = '{8, 8, 2};
  localparam int PN [3] = '{2, 2, 1};
  localparam int PD [3] = '{2, 2, 1};
  localparam int PL [3] = '{3, 3, 1};
  localparam int PM [3] = '{1, 0, 1};

  logic        clk;
  logic        rst_n;
  logic        start_w [3];
  logic [15:0] wf_a, wf_b;
  logic [1:0]  wf_c;
  logic        busy_w [3], done_w [3], sdata_w [3], sclk_w [3], le_w [3];

  int unsigned sh [3];
  int          nb [3], rxn [3], leln [3], bsn [3], lc [3], bc [3], dn [3], ov [3];
  int unsigned rxw [3][32];
  int          rxb [3][32], lel [3][32], bsl [3][32], brise [3][32];
  bit          dafter [3][32];
  bit          sclk_p [3], le_p [3];
  int          cyc, errs, checks;
  int          r0, lp, rp, dp, b0, tw;
  int unsigned wc;

  serial_word_loader #(.WORD_W(8), .N_WORDS(2), .DIV(2), .LE_HOLD(3), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .words_flat(wf_a),
    .busy(busy_w[0]), .done(done_w[0]), .sdata(sdata_w[0]), .sclk(sclk_w[0]), .le(le_w[0]));

  serial_word_loader #(.WORD_W(8), .N_WORDS(2), .DIV(2), .LE_HOLD(3), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .words_flat(wf_b),
    .busy(busy_w[1]), .done(done_w[1]), .sdata(sdata_w[1]), .sclk(sclk_w[1]), .le(le_w[1]));

  serial_word_loader #(.WORD_W(2), .N_WORDS(1), .DIV(1), .LE_HOLD(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .words_flat(wf_c),
    .busy(busy_w[2]), .done(done_w[2]), .sdata(sdata_w[2]), .sclk(sclk_w[2]), .le(le_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  // Received stream with the first bit on the wire in the top position.
  function automatic int unsigned exp_stream(int unsigned w, int n, int msb);
    int unsigned r;
    if (msb != 0) return w;
    r = 0;
    for (int i = 0; i < n; i++) r = (r << 1) | ((w >> i) & 1);
    return r;
  endfunction

  function automatic int outs(int k);
    return int'({busy_w[k], done_w[k], sdata_w[k], sclk_w[k], le_w[k]});
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and record pin activity of every DUT.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sh[k] = 0; nb[k] = 0; lc[k] = 0; bc[k] = 0;
      end else begin
        if (sclk_w[k] && !sclk_p[k]) begin
          sh[k] = (sh[k] << 1) | 32'(sdata_w[k]);
          nb[k]++;
        end
        if (le_w[k] && !le_p[k]) begin
          rxw[k][rxn[k] % 32] = sh[k];
          rxb[k][rxn[k] % 32] = nb[k];
          rxn[k]++;
          sh[k] = 0; nb[k] = 0;
        end
        if (le_w[k]) lc[k]++;
        else if (lc[k] > 0) begin
          lel[k][leln[k] % 32] = lc[k];
          leln[k]++;
          lc[k] = 0;
        end
        if (busy_w[k]) begin
          if (bc[k] == 0) brise[k][bsn[k] % 32] = cyc;
          bc[k]++;
        end else if (bc[k] > 0) begin
          bsl[k][bsn[k] % 32]    = bc[k];
          dafter[k][bsn[k] % 32] = done_w[k];
          bsn[k]++;
          bc[k] = 0;
        end
      end
      if (done_w[k]) dn[k]++;
      if (le_w[k] && sclk_w[k]) ov[k]++;
      sclk_p[k] = sclk_w[k];
      le_p[k]   = le_w[k];
    end
  endtask

  task automatic set_words(int k, int unsigned w0, int unsigned w1);
    case (k)
      0:       wf_a = {w1[7:0], w0[7:0]};
      1:       wf_b = {w1[7:0], w0[7:0]};
      default: wf_c = w0[1:0];
    endcase
  endtask

  // One full sequence on DUT k; churn scrambles words_flat and start while busy.
  task automatic send(int k, int unsigned w0, int unsigned w1, bit churn);
    int s_r0, s_l0, s_b0, s_d0, s_tw;
    int unsigned m;
    int unsigned ew [2];
    m = (32'd1 << PW[k]) - 1;
    ew[0] = w0 & m;
    ew[1] = w1 & m;
    s_r0 = rxn[k]; s_l0 = leln[k]; s_b0 = bsn[k]; s_d0 = dn[k];
    set_words(k, w0, w1);
    start_w[k] = 1'b1;
    tick();
    start_w[k] = 1'b0;
    for (int t = 0; t < 3000 && bsn[k] == s_b0; t++) begin
      tick();
      if (churn && bsn[k] == s_b0) begin
        set_words(k, $urandom, $urandom);
        start_w[k] = 1'($urandom_range(0, 1));
      end
    end
    start_w[k] = 1'b0;
    chk("sequence_end", int'(bsn[k] != s_b0), 1);
    if (bsn[k] != s_b0) begin
      s_tw = int'(word_cycles(PW[k], PD[k], PL[k]));
      chk("busy_len", bsl[k][s_b0 % 32], PN[k] * s_tw);
      chk("done_after_busy", int'(dafter[k][s_b0 % 32]), 1);
      chk("done_count", dn[k] - s_d0, 1);
      chk("word_count", rxn[k] - s_r0, PN[k]);
      chk("le_count", leln[k] - s_l0, PN[k]);
      for (int i = 0; i < PN[k]; i++) begin
        chk("word_data", int'(rxw[k][(s_r0 + i) % 32]), int'(exp_stream(ew[i], PW[k], PM[k])));
        chk("word_bits", rxb[k][(s_r0 + i) % 32], PW[k]);
        chk("le_len", lel[k][(s_l0 + i) % 32], PL[k]);
      end
      chk("le_sclk_overlap", ov[k], 0);
    end
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0;
    rst_n = 1'b0;
    wf_a = '0; wf_b = '0; wf_c = '0;
    for (int k = 0; k < 3; k++) start_w[k] = 1'b1;

    // Reset with start asserted, then release with start low.
    tick(); tick();
    for (int k = 0; k < 3; k++) chk("reset_outputs", outs(k), 0);
    for (int k = 0; k < 3; k++) start_w[k] = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) chk("idle_outputs", outs(k), 0);

    // MSB first, directed then random words; 78-cycle busy window.
    send(0, 32'hA5, 32'h3C, 1'b0);
    chk("busy_78", bsl[0][(bsn[0] - 1) % 32], 78);
    for (int n = 0; n < 3; n++) send(0, $urandom, $urandom, 1'b0);

    // LSB first.
    send(1, 32'h01, 32'h80, 1'b0);
    chk("lsb_word0_stream", int'(rxw[1][(rxn[1] - 2) % 32]), 32'h80);
    chk("lsb_word1_stream", int'(rxw[1][(rxn[1] - 1) % 32]), 32'h01);
    for (int n = 0; n < 3; n++) send(1, $urandom, $urandom, 1'b0);

    // Inputs scrambled while busy: snapshot is sent, no restart.
    send(0, $urandom, $urandom, 1'b1);
    send(1, $urandom, $urandom, 1'b1);

    // Asynchronous reset in the middle of word 1.
    set_words(0, $urandom, $urandom);
    r0 = rxn[0];
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    for (int t = 0; t < 2000 && !((rxn[0] - r0 >= 1) && (nb[0] >= 4)); t++) tick();
    chk("reach_word1_bit4", int'((rxn[0] - r0 >= 1) && (nb[0] >= 4)), 1);
    lp = leln[0]; rp = rxn[0]; dp = dn[0];
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs(0), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("abort_outputs", outs(0), 0);
    chk("abort_no_le", leln[0] - lp + (rxn[0] - rp), 0);
    chk("abort_no_done", dn[0] - dp, 0);
    send(0, $urandom, $urandom, 1'b0);

    // Minimal configuration with start held high: 7 busy + 1 done, period 8.
    wc = $urandom_range(0, 3);
    set_words(2, wc, 0);
    b0 = bsn[2]; r0 = rxn[2]; dp = dn[2];
    start_w[2] = 1'b1;
    for (int t = 0; t < 40; t++) tick();
    start_w[2] = 1'b0;
    for (int t = 0; t < 100 && busy_w[2]; t++) tick();
    tick(); tick();
    chk("held_idle_after", outs(2), 0);
    chk("held_runs_ge4", int'(bsn[2] - b0 >= 4), 1);
    chk("held_done_matches_runs", dn[2] - dp, bsn[2] - b0);
    tw = int'(word_cycles(2, 1, 1));
    if (bsn[2] - b0 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("held_busy_len", bsl[2][(b0 + i) % 32], tw);
        chk("held_done_after", int'(dafter[2][(b0 + i) % 32]), 1);
        chk("held_word", int'(rxw[2][(r0 + i) % 32]), int'(wc));
      end
      for (int i = 0; i < 3; i++)
        chk("held_period", brise[2][(b0 + i + 1) % 32] - brise[2][(b0 + i) % 32], 8);
    end
    chk("held_le_sclk_overlap", ov[2], 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
